// File: rtl/h2c_ctrl.sv
// H2C capture sequencer: gates packet acceptance, kicks the DUT once per
// received packet and waits for its completion, with optional timeout and abort.
module h2c_ctrl #(
  parameter int PKT_CNT_WIDTH = 16,
  parameter int TIMEOUT_WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic                     cfg_abort,
  input  logic [PKT_CNT_WIDTH-1:0] cfg_pkt_num,
  input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
  output logic                     ctrl_h2c_en,
  input  logic                     ctrl_h2c_pkt_done,
  output logic                     dut_start,
  input  logic                     dut_done,
  output logic                     status_busy,
  output logic                     status_done,
  output logic                     status_timeout,
  output logic                     status_aborted,
  output logic [PKT_CNT_WIDTH-1:0] status_pkt_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    KICK = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t                   r_state;
  logic [PKT_CNT_WIDTH-1:0] r_pkt_num;
  logic [PKT_CNT_WIDTH-1:0] r_pkt_cnt;
  logic [TIMEOUT_WIDTH-1:0] r_timeout;
  logic [TIMEOUT_WIDTH-1:0] r_to_cnt;
  logic                     r_h2c_en;
  logic                     r_dut_start;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_timed_out;
  logic                     r_aborted;

  logic [PKT_CNT_WIDTH-1:0] w_cnt_next;
  logic                     w_last_pkt;
  logic                     w_to_hit;

  assign w_cnt_next = r_pkt_cnt + 1'b1;
  assign w_last_pkt = (w_cnt_next == r_pkt_num);
  // A zero timeout disables the limit; otherwise WAIT lasts at most r_timeout cycles.
  assign w_to_hit   = (r_timeout != '0) && (r_to_cnt == (r_timeout - 1'b1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pkt_num   <= '0;
      r_pkt_cnt   <= '0;
      r_timeout   <= '0;
      r_to_cnt    <= '0;
      r_h2c_en    <= 1'b0;
      r_dut_start <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timed_out <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      r_dut_start <= 1'b0;
      if (cfg_abort && (r_state != IDLE)) begin
        r_state   <= IDLE;
        r_h2c_en  <= 1'b0;
        r_busy    <= 1'b0;
        r_aborted <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            // A simultaneous abort drops the start request.
            if (cfg_start && !cfg_abort) begin
              r_pkt_cnt   <= '0;
              r_done      <= 1'b0;
              r_timed_out <= 1'b0;
              r_aborted   <= 1'b0;
              if (cfg_pkt_num != '0) begin
                r_pkt_num <= cfg_pkt_num;
                r_timeout <= cfg_timeout;
                r_state   <= RECV;
                r_h2c_en  <= 1'b1;
                r_busy    <= 1'b1;
              end else begin
                r_done    <= 1'b1;
              end
            end
          end
          RECV: begin
            // Dropping the enable on the tlast edge blocks any further beat.
            if (ctrl_h2c_pkt_done) begin
              r_state     <= KICK;
              r_h2c_en    <= 1'b0;
              r_dut_start <= 1'b1;
            end
          end
          KICK: begin
            r_state  <= WAIT;
            r_to_cnt <= '0;
          end
          WAIT: begin
            if (dut_done) begin
              r_pkt_cnt <= w_cnt_next;
              if (w_last_pkt) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state  <= RECV;
                r_h2c_en <= 1'b1;
              end
            end else if (w_to_hit) begin
              r_state     <= IDLE;
              r_busy      <= 1'b0;
              r_timed_out <= 1'b1;
            end else begin
              r_to_cnt <= r_to_cnt + 1'b1;
            end
          end
          default: begin
            r_state  <= IDLE;
            r_h2c_en <= 1'b0;
            r_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ctrl_h2c_en    = r_h2c_en;
  assign dut_start      = r_dut_start;
  assign status_busy    = r_busy;
  assign status_done    = r_done;
  assign status_timeout = r_timed_out;
  assign status_aborted = r_aborted;
  assign status_pkt_cnt = r_pkt_cnt;

endmodule
